// File: rtl/control_unit.sv
// control_unit: instruction sequencer for the 16-bit machine.
// Fetches from the 128-word memory/IO bus, loads the ALU operand registers,
// selects the ALU operation, writes results back and keeps the zero flag.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | read M[PC] into IR when run=1; PC advances on completion
// DECODE | BEQ resolves here (taken if Z); other opcodes go read F
// RD_SRC | read M[F] into B
// RD_DST | read M[D] into A (ADD and CMP only)
// EXEC   | capture ALU result into R and zero indication into Z
// WRITE  | write R to M[D] (MOV and ADD only)
module control_unit #(
    parameter logic [6:0] RESET_PC = 7'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        mem_en,
    output logic        mem_we,
    output logic [6:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        alu_z,
    output logic        z_flag,
    output logic [6:0]  pc,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_RD_SRC = 3'd2,
        S_RD_DST = 3'd3,
        S_EXEC   = 3'd4,
        S_WRITE  = 3'd5
    } state_t;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_XOR   = 2'd1;
    localparam logic [1:0] ALU_PASSB = 2'd2;

    state_t      state, state_nx;
    logic [6:0]  pc_q, pc_nx;
    logic [15:0] ir_q, ir_nx;
    logic [15:0] a_q, a_nx;
    logic [15:0] b_q, b_nx;
    logic [15:0] r_q, r_nx;
    logic        z_q, z_nx;

    logic [1:0]  opcode;
    logic [6:0]  src_addr;
    logic [6:0]  dst_addr;

    assign opcode   = ir_q[15:14];
    assign src_addr = ir_q[13:7];
    assign dst_addr = ir_q[6:0];

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign z_flag = z_q;
    assign pc     = pc_q;

    // State and datapath registers; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc_q  <= RESET_PC;
            ir_q  <= 16'd0;
            a_q   <= 16'd0;
            b_q   <= 16'd0;
            r_q   <= 16'd0;
            z_q   <= 1'b0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            ir_q  <= ir_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
            r_q   <= r_nx;
            z_q   <= z_nx;
        end
    end

    // Next-state, register updates and bus/ALU control decoded from state.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc_q;
        ir_nx     = ir_q;
        a_nx      = a_q;
        b_nx      = b_q;
        r_nx      = r_q;
        z_nx      = z_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = 16'd0;
        alu_op    = ALU_PASSB;
        busy      = (state != S_FETCH);

        case (state)
            S_FETCH: begin
                mem_en   = run;
                mem_addr = pc_q;
                if (run && mem_ready) begin
                    ir_nx    = mem_rdata;
                    pc_nx    = pc_q + 7'd1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_BEQ) begin
                    if (z_q) begin
                        pc_nx = dst_addr;
                    end
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_RD_SRC;
                end
            end
            S_RD_SRC: begin
                mem_en   = 1'b1;
                mem_addr = src_addr;
                if (mem_ready) begin
                    b_nx     = mem_rdata;
                    state_nx = (opcode == OP_MOV) ? S_EXEC : S_RD_DST;
                end
            end
            S_RD_DST: begin
                mem_en   = 1'b1;
                mem_addr = dst_addr;
                if (mem_ready) begin
                    a_nx     = mem_rdata;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_CMP:  alu_op = ALU_XOR;
                    default: alu_op = ALU_PASSB;
                endcase
                r_nx     = alu_out;
                z_nx     = alu_z;
                state_nx = (opcode == OP_CMP) ? S_FETCH : S_WRITE;
            end
            S_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_addr;
                mem_wdata = r_q;
                if (mem_ready) begin
                    state_nx = S_FETCH;
                end
            end
            default: begin
                state_nx = S_FETCH;
            end
        endcase

        // Bus strobes are suppressed while reset is held so an in-flight
        // access is abandoned in the same cycle reset arrives.
        if (!rst_n) begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_wdata = 16'd0;
            alu_op    = ALU_PASSB;
            busy      = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table vectors, directed corner sequences and a random
// program run checked against an instruction-level reference model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_en;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_z;
    logic        z_flag;
    logic [6:0]  pc;
    logic        busy;

    always #5 clk = ~clk;

    control_unit #(.RESET_PC(7'd0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_z     (alu_z),
        .z_flag    (z_flag),
        .pc        (pc),
        .busy      (busy)
    );

    // Environment: memory and ALU
    logic [15:0] mem [128];
    int          wr_cnt = 0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_en && mem_we && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    always_comb begin
        case (alu_op)
            2'd0:    alu_out = alu_a + alu_b;
            2'd1:    alu_out = alu_a ^ alu_b;
            2'd2:    alu_out = alu_b;
            default: alu_out = ~alu_b;
        endcase
        alu_z = (alu_out == 16'd0);
    end

    // Checking infrastructure
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic       rpat [64];
    logic       tr_en [64];
    logic [6:0] tr_addr [64];

    task automatic rpat_ones();
        for (int k = 0; k < 64; k++) rpat[k] = 1'b1;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 128; k++) mem[k] = 16'd0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction from FETCH; returns the cycles spent after the
    // fetch edge until FETCH is re-entered. Applies rpat to mem_ready.
    task automatic step(input bit drop_run, output int cyc);
        int t;
        run       = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        if (drop_run) run = 1'b0;
        t   = 0;
        cyc = -1;
        while (t < 60) begin
            @(negedge clk);
            tr_en[t]   = mem_en;
            tr_addr[t] = mem_addr;
            if (!busy) begin
                cyc = t;
                break;
            end
            mem_ready = rpat[t];
            t++;
        end
        mem_ready = 1'b1;
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: got no return to fetch expected within 60 cycles");
        end
    endtask

    // Reference model: instruction-level interpreter
    logic [15:0] mem_ref [128];
    logic [6:0]  pc_ref;
    logic        z_ref;

    // Phases after the fetch: 'i' internal cycle, 'a' bus access that
    // lasts until the ready pattern shows a 1.
    function automatic int model_cycles(input logic [1:0] op);
        string s;
        int    t;
        case (op)
            2'b00:   s = "iaia";
            2'b01:   s = "iaaia";
            2'b10:   s = "iaai";
            default: s = "i";
        endcase
        t = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) == "a") begin
                while (t < 60 && !rpat[t]) t++;
            end
            t++;
        end
        return t;
    endfunction

    task automatic iss_step(output int exp_cyc);
        logic [15:0] ins;
        logic [15:0] res;
        logic [1:0]  op;
        logic [6:0]  f;
        logic [6:0]  d;
        ins    = mem_ref[pc_ref];
        op     = ins[15:14];
        f      = ins[13:7];
        d      = ins[6:0];
        pc_ref = pc_ref + 7'd1;
        case (op)
            2'b00: begin
                res        = mem_ref[f];
                mem_ref[d] = res;
                z_ref      = (res == 16'd0);
            end
            2'b01: begin
                res        = mem_ref[d] + mem_ref[f];
                mem_ref[d] = res;
                z_ref      = (res == 16'd0);
            end
            2'b10: begin
                z_ref = (mem_ref[d] == mem_ref[f]);
            end
            default: begin
                if (z_ref) pc_ref = d;
            end
        endcase
        exp_cyc = model_cycles(op);
    endtask

    // Table vectors: single instructions at address 0 with F=10, D=11
    typedef struct {
        logic [15:0] ins;
        logic [15:0] vf;
        logic [15:0] vd;
        logic [15:0] exp_d;
        logic        exp_z;
        int          exp_cyc;
        int          exp_wr;
    } vec_t;

    vec_t vt [7];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $fatal(1);
    end

    initial begin : main
        int cyc;
        int w0;
        int exp_cyc;
        int nmis;

        vt[0] = '{16'h050B, 16'h1234, 16'hAAAA, 16'h1234, 1'b0, 5, 1};
        vt[1] = '{16'h050B, 16'h0000, 16'h5555, 16'h0000, 1'b1, 5, 1};
        vt[2] = '{16'h450B, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 6, 1};
        vt[3] = '{16'h450B, 16'h1111, 16'h1234, 16'h2345, 1'b0, 6, 1};
        vt[4] = '{16'h850B, 16'h5A5A, 16'h5A5A, 16'h5A5A, 1'b1, 5, 0};
        vt[5] = '{16'h850B, 16'h0001, 16'h0002, 16'h0002, 1'b0, 5, 0};
        vt[6] = '{16'h850B, 16'h8000, 16'h0000, 16'h0000, 1'b0, 5, 0};

        rpat_ones();
        clear_mem();

        // Reset values, sampled while reset is held
        rst_n     = 1'b0;
        run       = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_op", alu_op, 2'd2);
        chk("rst_wdata", mem_wdata, 16'd0);
        chk("rst_pc", pc, 7'd0);
        chk("rst_z", z_flag, 1'b0);
        chk("rst_alu_a", alu_a, 16'd0);
        chk("rst_alu_b", alu_b, 16'd0);
        rst_n = 1'b1;
        run   = 1'b0;

        // Table-driven single instructions
        for (int v = 0; v < 7; v++) begin
            do_reset();
            clear_mem();
            mem[0]  = vt[v].ins;
            mem[10] = vt[v].vf;
            mem[11] = vt[v].vd;
            rpat_ones();
            w0 = wr_cnt;
            step(1'b1, cyc);
            chk($sformatf("vec%0d_cycles", v), cyc + 1, vt[v].exp_cyc);
            chk($sformatf("vec%0d_md", v), mem[11], vt[v].exp_d);
            chk($sformatf("vec%0d_z", v), z_flag, vt[v].exp_z);
            chk($sformatf("vec%0d_pc", v), pc, 7'd1);
            chk($sformatf("vec%0d_writes", v), wr_cnt - w0, vt[v].exp_wr);
        end

        // MOV F=1 D=3 from reset, then a stall with run low, then ADD with
        // run dropped after the fetch
        do_reset();
        clear_mem();
        mem[0]  = 16'h0083;
        mem[1]  = 16'h1234;
        step(1'b0, cyc);
        run = 1'b0;
        chk("mov_cycles", cyc + 1, 5);
        chk("mov_m3", mem[3], 16'h1234);
        chk("mov_z", z_flag, 1'b0);
        chk("mov_pc", pc, 7'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_mem_en", mem_en, 1'b0);
            chk("stall_busy", busy, 1'b0);
            chk("stall_pc", pc, 7'd1);
        end
        mem[1]  = 16'h4A15;
        mem[20] = 16'h0002;
        mem[21] = 16'h0003;
        step(1'b1, cyc);
        chk("droprun_cycles", cyc + 1, 6);
        chk("droprun_m21", mem[21], 16'h0005);
        chk("droprun_pc", pc, 7'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("droprun_stall_en", mem_en, 1'b0);
            chk("droprun_stall_pc", pc, 7'd2);
        end

        // ADD with three wait cycles in the destination read
        do_reset();
        clear_mem();
        mem[0]  = 16'h4A15;
        mem[20] = 16'h0001;
        mem[21] = 16'hFFFF;
        rpat_ones();
        rpat[2] = 1'b0;
        rpat[3] = 1'b0;
        rpat[4] = 1'b0;
        step(1'b1, cyc);
        chk("wait_cycles", cyc + 1, 9);
        chk("wait_m21", mem[21], 16'h0000);
        chk("wait_z", z_flag, 1'b1);
        for (int t = 2; t < 6; t++) begin
            chk("wait_mem_en", tr_en[t], 1'b1);
            chk("wait_mem_addr", tr_addr[t], 7'd21);
        end
        rpat_ones();

        // CMP equal then BEQ taken; CMP unequal then BEQ not taken
        do_reset();
        clear_mem();
        mem[0]    = 16'h850B;
        mem[10]   = 16'h0777;
        mem[11]   = 16'h0777;
        mem[1]    = 16'hC040;
        mem[7'h40] = 16'h850C;
        mem[12]   = 16'h0778;
        mem[7'h41] = 16'hC005;
        w0 = wr_cnt;
        step(1'b0, cyc);
        chk("cmp_eq_cycles", cyc + 1, 5);
        chk("cmp_eq_nowrite", wr_cnt - w0, 0);
        chk("cmp_eq_z", z_flag, 1'b1);
        step(1'b0, cyc);
        chk("beq_taken_cycles", cyc + 1, 2);
        chk("beq_taken_pc", pc, 7'h40);
        step(1'b0, cyc);
        chk("cmp_ne_z", z_flag, 1'b0);
        step(1'b1, cyc);
        chk("beq_not_taken_pc", pc, 7'h42);
        chk("beq_not_taken_cycles", cyc + 1, 2);

        // BEQ not taken at address 127 wraps to 0
        do_reset();
        clear_mem();
        mem[0]   = 16'h850A;
        mem[1]   = 16'hC07E;
        mem[126] = 16'h850B;
        mem[127] = 16'hC005;
        mem[10]  = 16'h0001;
        mem[11]  = 16'h0002;
        step(1'b0, cyc);
        step(1'b0, cyc);
        chk("wrap_beq_pc", pc, 7'd126);
        step(1'b0, cyc);
        chk("wrap_cmp_pc", pc, 7'd127);
        chk("wrap_cmp_z", z_flag, 1'b0);
        step(1'b1, cyc);
        chk("wrap_pc", pc, 7'd0);

        // Reset during a stalled WRITE
        do_reset();
        clear_mem();
        mem[0]  = 16'h850A;
        mem[1]  = 16'h050B;
        mem[10] = 16'h0001;
        mem[11] = 16'hBEEF;
        step(1'b0, cyc);
        chk("rstw_pre_z", z_flag, 1'b1);
        run       = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (4) @(negedge clk);
        mem_ready = 1'b0;
        w0 = wr_cnt;
        chk("rstw_in_write", mem_we, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw_hold_we", mem_we, 1'b0);
        chk("rstw_hold_en", mem_en, 1'b0);
        chk("rstw_hold_busy", busy, 1'b0);
        chk("rstw_hold_wdata", mem_wdata, 16'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_pc", pc, 7'd0);
        chk("rstw_we", mem_we, 1'b0);
        chk("rstw_z", z_flag, 1'b0);
        chk("rstw_nowrite", wr_cnt - w0, 0);
        chk("rstw_m11", mem[11], 16'hBEEF);

        // Random program with random wait states against the reference model
        do_reset();
        for (int k = 0; k < 128; k++) begin
            if ($urandom_range(0, 1) == 1)
                mem[k] = 16'($urandom);
            else
                mem[k] = {2'($urandom_range(0, 3)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
            mem_ref[k] = mem[k];
        end
        pc_ref = 7'd0;
        z_ref  = 1'b0;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 64; k++) rpat[k] = ($urandom_range(0, 3) != 0);
            iss_step(exp_cyc);
            step(1'b0, cyc);
            chk("rand_cycles", cyc, exp_cyc);
            chk("rand_pc", pc, pc_ref);
            chk("rand_z", z_flag, z_ref);
        end
        run = 1'b0;
        rpat_ones();
        @(negedge clk);
        nmis = 0;
        for (int k = 0; k < 128; k++) begin
            if (mem[k] !== mem_ref[k]) nmis++;
        end
        chk("rand_mem_mismatches", nmis, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
